// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Function : Pipeline hazard unit; tracks EXE/MEM producers and HI/LO busy time,
//            drives the registered EXE forward selects and the ID stall.
// Options  : HAZARD_FWD_EN (defined = forwarding, undefined = stall-only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ID_Valid,
    input  logic [4:0] ID_RegA,
    input  logic [4:0] ID_RegB,
    input  logic       ID_UsesA,
    input  logic       ID_UsesB,
    input  logic       ID_IsStore,
    input  logic [4:0] ID_WriteReg,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_IsMulDiv,
    input  logic       ID_ReadsHiLo,
    output logic [1:0] RegA_Select,
    output logic [1:0] RegB_Select,
    output logic [1:0] MEM_Data_select,
    output logic       Stall
);

    localparam logic [1:0] c_SEL_RF   = 2'd0;
    localparam logic [1:0] c_SEL_MEM  = 2'd1;
    localparam logic [1:0] c_SEL_WB   = 2'd2;
    localparam logic [3:0] c_BUSY_LAT = 4'(MULDIV_LAT);

    logic       r_e_valid, r_e_regwrite, r_e_load;
    logic [4:0] r_e_reg;
    logic       r_m_valid, r_m_regwrite, r_m_load;
    logic [4:0] r_m_reg;
    logic [3:0] r_busy;

    logic       w_uses_b;
    logic       w_hit_e_a, w_hit_e_b, w_hit_m_a, w_hit_m_b;
    logic       w_data_stall, w_hilo_stall, w_issue;
    logic [1:0] w_sel_a, w_sel_b;

    always_comb begin
        // A store always reads RegB for its data, whatever ID_UsesB says.
        w_uses_b  = ID_IsStore | ID_UsesB;
        w_hit_e_a = r_e_valid & r_e_regwrite & (ID_RegA != 5'd0) & (ID_RegA == r_e_reg) & ID_UsesA;
        w_hit_e_b = r_e_valid & r_e_regwrite & (ID_RegB != 5'd0) & (ID_RegB == r_e_reg) & w_uses_b;
        w_hit_m_a = r_m_valid & r_m_regwrite & (ID_RegA != 5'd0) & (ID_RegA == r_m_reg) & ID_UsesA;
        w_hit_m_b = r_m_valid & r_m_regwrite & (ID_RegB != 5'd0) & (ID_RegB == r_m_reg) & w_uses_b;

`ifdef HAZARD_FWD_EN
        // A load in EXE has no result yet; once it reaches MEM it forwards from WB.
        w_data_stall = r_e_load & (w_hit_e_a | w_hit_e_b);
        w_sel_a      = w_hit_e_a ? c_SEL_MEM : (w_hit_m_a ? c_SEL_WB : c_SEL_RF);
        w_sel_b      = w_hit_e_b ? c_SEL_MEM : (w_hit_m_b ? c_SEL_WB : c_SEL_RF);
`else
        w_data_stall = w_hit_e_a | w_hit_e_b | w_hit_m_a | w_hit_m_b;
        w_sel_a      = c_SEL_RF;
        w_sel_b      = c_SEL_RF;
`endif

        w_hilo_stall = (r_busy != 4'd0) & (ID_ReadsHiLo | ID_IsMulDiv);
        Stall        = RESET & ID_Valid & (w_data_stall | w_hilo_stall);
        w_issue      = ID_Valid & ~Stall;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_e_valid       <= 1'b0;
            r_e_regwrite    <= 1'b0;
            r_e_load        <= 1'b0;
            r_e_reg         <= 5'd0;
            r_m_valid       <= 1'b0;
            r_m_regwrite    <= 1'b0;
            r_m_load        <= 1'b0;
            r_m_reg         <= 5'd0;
            r_busy          <= 4'd0;
            RegA_Select     <= c_SEL_RF;
            RegB_Select     <= c_SEL_RF;
            MEM_Data_select <= c_SEL_RF;
        end else begin
            r_m_valid    <= r_e_valid;
            r_m_regwrite <= r_e_regwrite;
            r_m_load     <= r_e_load;
            r_m_reg      <= r_e_reg;

            r_e_valid    <= w_issue;
            r_e_regwrite <= w_issue & ID_RegWrite;
            r_e_load     <= w_issue & ID_MemRead;
            r_e_reg      <= w_issue ? ID_WriteReg : 5'd0;

            if (w_issue && ID_IsMulDiv)
                r_busy <= c_BUSY_LAT;
            else if (r_busy != 4'd0)
                r_busy <= r_busy - 4'd1;

            if (w_issue) begin
                RegA_Select     <= w_sel_a;
                RegB_Select     <= ID_IsStore ? c_SEL_RF : w_sel_b;
                MEM_Data_select <= ID_IsStore ? w_sel_b : c_SEL_RF;
            end else begin
                RegA_Select     <= c_SEL_RF;
                RegB_Select     <= c_SEL_RF;
                MEM_Data_select <= c_SEL_RF;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Function : Self-checking bench for hazard_ctrl (honours HAZARD_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int LAT = 4;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ID_Valid, ID_UsesA, ID_UsesB, ID_IsStore;
    logic [4:0] ID_RegA, ID_RegB, ID_WriteReg;
    logic       ID_RegWrite, ID_MemRead, ID_IsMulDiv, ID_ReadsHiLo;
    logic [1:0] RegA_Select, RegB_Select, MEM_Data_select;
    logic       Stall;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .ID_Valid(ID_Valid),
        .ID_RegA(ID_RegA), .ID_RegB(ID_RegB),
        .ID_UsesA(ID_UsesA), .ID_UsesB(ID_UsesB), .ID_IsStore(ID_IsStore),
        .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
        .RegA_Select(RegA_Select), .RegB_Select(RegB_Select),
        .MEM_Data_select(MEM_Data_select), .Stall(Stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: instructions in flight ----------------
    typedef struct {
        bit       v;
        bit       rw;
        bit [4:0] rd;
        bit       ld;
    } slot_t;

    slot_t pipe [2];          // [0] = EXE, [1] = MEM
    int    cyc     = 0;       // edges since reset
    int    free_at = 0;       // first cycle HI/LO is readable again
    int    exp_a = 0, exp_b = 0, exp_m = 0;

    function automatic bit hits(slot_t p, logic [4:0] r, logic uses);
        return p.v && p.rw && (r != 5'd0) && (p.rd == r) && (uses === 1'b1);
    endfunction

    function automatic bit m_stall();
        bit ub, data, hilo;
        if (RESET !== 1'b1 || ID_Valid !== 1'b1) return 1'b0;
        ub = ID_IsStore || ID_UsesB;
        if (FWD)
            data = pipe[0].ld && (hits(pipe[0], ID_RegA, ID_UsesA) || hits(pipe[0], ID_RegB, ub));
        else
            data = hits(pipe[0], ID_RegA, ID_UsesA) || hits(pipe[0], ID_RegB, ub) ||
                   hits(pipe[1], ID_RegA, ID_UsesA) || hits(pipe[1], ID_RegB, ub);
        hilo = (cyc < free_at) && (ID_ReadsHiLo || ID_IsMulDiv);
        return data || hilo;
    endfunction

    function automatic int src_sel(logic [4:0] r, logic uses);
        if (!FWD) return 0;
        if (hits(pipe[0], r, uses)) return 1;
        if (hits(pipe[1], r, uses)) return 2;
        return 0;
    endfunction

    initial begin
        bit st, iss;
        int sb;
        for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, rw: 0, rd: 0, ld: 0};
        forever begin
            @(posedge CLK or negedge RESET);
            if (RESET !== 1'b1) begin
                for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, rw: 0, rd: 0, ld: 0};
                cyc = 0; free_at = 0; exp_a = 0; exp_b = 0; exp_m = 0;
            end else begin
                st  = m_stall();
                iss = (ID_Valid === 1'b1) && !st;
                if (iss) begin
                    exp_a = src_sel(ID_RegA, ID_UsesA);
                    sb    = src_sel(ID_RegB, ID_IsStore || ID_UsesB);
                    exp_b = ID_IsStore ? 0 : sb;
                    exp_m = ID_IsStore ? sb : 0;
                end else begin
                    exp_a = 0; exp_b = 0; exp_m = 0;
                end
                pipe[1] = pipe[0];
                if (iss) pipe[0] = '{v: 1, rw: ID_RegWrite, rd: ID_WriteReg, ld: ID_MemRead};
                else     pipe[0] = '{v: 0, rw: 0, rd: 0, ld: 0};
                cyc++;
                if (iss && ID_IsMulDiv) free_at = cyc + LAT;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("stall",    int'(Stall),           int'(m_stall()));
            check("sel_a",    int'(RegA_Select),     exp_a);
            check("sel_b",    int'(RegB_Select),     exp_b);
            check("sel_mem",  int'(MEM_Data_select), exp_m);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit       v;
        bit [4:0] ra, rb, wr;
        bit       ua, ub, st, rw, mr, md, rh;
    } instr_t;

    function automatic instr_t mk(bit [4:0] ra, bit ua, bit [4:0] rb, bit ub, bit [4:0] wr, bit rw);
        instr_t x;
        x = '{v: 1, ra: ra, rb: rb, wr: wr, ua: ua, ub: ub, st: 0, rw: rw, mr: 0, md: 0, rh: 0};
        return x;
    endfunction

    task automatic drive(input instr_t x);
        ID_Valid = x.v;   ID_RegA = x.ra;  ID_RegB = x.rb;   ID_WriteReg = x.wr;
        ID_UsesA = x.ua;  ID_UsesB = x.ub; ID_IsStore = x.st; ID_RegWrite = x.rw;
        ID_MemRead = x.mr; ID_IsMulDiv = x.md; ID_ReadsHiLo = x.rh;
    endtask

    task automatic idle();
        instr_t x;
        x = '{default: 0};
        drive(x);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush();
        repeat (20) begin tick(); idle(); end
    endtask

    // Present x in ID and hold it while stalled; returns the stall-cycle count.
    task automatic present(input instr_t x, output int stalls);
        tick();
        drive(x);
        stalls = 0;
        forever begin
            @(negedge CLK);
            #1;
            if (Stall !== 1'b1) break;
            stalls++;
            if (stalls > 30) begin
                n_tests++; n_fail++;
                $display("FAIL stall_timeout: stall still high after %0d cycles", stalls);
                break;
            end
            tick();
        end
    endtask

    // Let the last presented instruction enter EXE and settle its selects.
    task automatic after_issue();
        tick();
        idle();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        instr_t addi3, add4, unrel, sub6, lw2, add7, addi0, add1, addi8, sw8, mult, mflo, rnd;
        int s;

        addi3 = mk(5'd1, 1, 5'd0, 0, 5'd3, 1);
        add4  = mk(5'd3, 1, 5'd5, 1, 5'd4, 1);
        unrel = mk(5'd10, 1, 5'd0, 0, 5'd9, 1);
        sub6  = mk(5'd5, 1, 5'd3, 1, 5'd6, 1);
        lw2   = mk(5'd1, 1, 5'd0, 0, 5'd2, 1); lw2.mr = 1;
        add7  = mk(5'd2, 1, 5'd2, 1, 5'd7, 1);
        addi0 = mk(5'd1, 1, 5'd0, 0, 5'd0, 1);
        add1  = mk(5'd0, 1, 5'd0, 1, 5'd1, 1);
        addi8 = mk(5'd1, 1, 5'd0, 0, 5'd8, 1);
        sw8   = mk(5'd9, 1, 5'd8, 0, 5'd0, 0); sw8.st = 1;
        mult  = mk(5'd4, 1, 5'd5, 1, 5'd0, 0); mult.md = 1;
        mflo  = mk(5'd0, 0, 5'd0, 0, 5'd6, 1); mflo.rh = 1;

        RESET = 1'b0;
        drive(add4);
        #1 chk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_stall", int'(Stall), 0);
        check("rst_sel_a", int'(RegA_Select), 0);
        check("rst_sel_b", int'(RegB_Select), 0);
        check("rst_sel_m", int'(MEM_Data_select), 0);
        RESET = 1'b1;
        flush();

        // producer directly ahead
        present(addi3, s);
        present(add4, s);
        check("raw_e_stalls", s, FWD ? 0 : 2);
        after_issue();
        check("raw_e_sel_a", int'(RegA_Select), FWD ? 1 : 0);
        check("raw_e_sel_b", int'(RegB_Select), 0);

        // producer two ahead
        flush();
        present(addi3, s);
        present(unrel, s);
        present(sub6, s);
        check("raw_m_stalls", s, FWD ? 0 : 1);
        after_issue();
        check("raw_m_sel_b", int'(RegB_Select), FWD ? 2 : 0);
        check("raw_m_sel_a", int'(RegA_Select), 0);

        // load-use
        flush();
        present(lw2, s);
        present(add7, s);
        check("ldu_stalls", s, FWD ? 1 : 2);
        after_issue();
        check("ldu_sel_a", int'(RegA_Select), FWD ? 2 : 0);
        check("ldu_sel_b", int'(RegB_Select), FWD ? 2 : 0);

        // r0 never forwards
        flush();
        present(addi0, s);
        present(add1, s);
        check("r0_stalls", s, 0);
        after_issue();
        check("r0_sel_a", int'(RegA_Select), 0);
        check("r0_sel_b", int'(RegB_Select), 0);

        // store data routing
        flush();
        present(addi8, s);
        present(sw8, s);
        check("sw_stalls", s, FWD ? 0 : 2);
        after_issue();
        check("sw_sel_mem", int'(MEM_Data_select), FWD ? 1 : 0);
        check("sw_sel_b", int'(RegB_Select), 0);

        // HI/LO busy window
        flush();
        present(mult, s);
        present(mflo, s);
        check("hilo_stalls", s, LAT);
        after_issue();

        // reset abandons a HI/LO stall
        flush();
        present(mult, s);
        tick();
        drive(mflo);
        @(negedge CLK);
        #1;
        check("hilo_pre_rst_stall", int'(Stall), 1);
        #2 RESET = 1'b0;
        #1;
        check("hilo_rst_stall", int'(Stall), 0);
        check("hilo_rst_sel_a", int'(RegA_Select), 0);
        tick();
        RESET = 1'b1;
        present(mflo, s);
        check("hilo_post_rst_stalls", s, 0);
        after_issue();

        // randomized traffic over a small register set
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 199) == 0) RESET = 1'b0;
            else RESET = 1'b1;
            rnd.v  = ($urandom_range(0, 7) != 0);
            rnd.ra = 5'($urandom_range(0, 3));
            rnd.rb = 5'($urandom_range(0, 3));
            rnd.wr = 5'($urandom_range(0, 3));
            rnd.ua = 1'($urandom);
            rnd.ub = 1'($urandom);
            rnd.st = ($urandom_range(0, 4) == 0);
            rnd.rw = ($urandom_range(0, 3) != 0);
            rnd.mr = ($urandom_range(0, 3) == 0);
            rnd.md = ($urandom_range(0, 9) == 0);
            rnd.rh = ($urandom_range(0, 5) == 0);
            drive(rnd);
        end
        tick();
        RESET = 1'b1;
        idle();
        repeat (3) @(posedge CLK);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
